mult_div_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit for the MIPS core.
- Executes MULT/MULTU/DIV/DIVU over WIDTH+2 cycles and holds results in the architectural HI/LO registers.
- HI and LO feed the EX-stage 4:1 result-select mux directly as two of its 32-bit data inputs. MFHI/MFLO select them there.
- Also services MTHI/MTLO writes. The pipeline stalls on busy.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the decoder that drives its op field.
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   // op field encodings: bit 1 selects divide, bit 0 selects unsigned
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_e;

   // One shift-add / shift-subtract step per operand bit
   localparam int unsigned MDU_ITERS = MDU_WIDTH;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: magnitude shift-add multiply and restoring
// divide over WIDTH iterations, followed by a sign-fix cycle that writes HI/LO.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mdu_state_e         state_q;
   logic [CW-1:0]      cnt_q;
   logic               div_q;
   logic               neg_q;     // negate product / quotient
   logic               rneg_q;    // negate remainder
   logic [WIDTH-1:0]   a_q;       // raw dividend, returned in HI on divide-by-zero
   logic [WIDTH-1:0]   opd_q;     // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;     // product, or remainder:quotient
   logic [2*WIDTH-1:0] acc_d;
   logic               busy_q, done_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               sa, sb;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem;
   logic [WIDTH-1:0]   hi_fix, lo_fix;

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // Operand magnitudes and signs taken at launch
   always_comb begin
      sa    = op_is_signed(op) & a[WIDTH-1];
      sb    = op_is_signed(op) & b[WIDTH-1];
      a_mag = sa ? -a : a;
      b_mag = sb ? -b : b;
   end

   // One iteration: add-or-pass then shift right (multiply), shift then subtract-or-restore (divide)
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
      div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_sh - {1'b0, opd_q};
      acc_d    = acc_q;
      if (div_q) begin
         if (div_diff[WIDTH])
            acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         else
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         if (acc_q[0])
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         else
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
   end

   // Sign correction of the finished magnitude result
   always_comb begin
      prod   = neg_q ? -acc_q : acc_q;
      quot   = acc_q[WIDTH-1:0];
      rem    = acc_q[2*WIDTH-1:WIDTH];
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
      if (div_q) begin
         if (opd_q == '0) begin
            hi_fix = a_q;
            lo_fix = '1;
         end else begin
            hi_fix = rneg_q ? -rem : rem;
            lo_fix = neg_q ? -quot : quot;
         end
      end
   end

   // Control FSM with registered busy/done/HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         a_q     <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  div_q  <= op_is_div(op);
                  neg_q  <= sa ^ sb;
                  rneg_q <= sa;
                  a_q    <= a;
                  opd_q  <= op_is_div(op) ? b_mag : a_mag;
                  acc_q  <= {{WIDTH{1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
                  cnt_q  <= CW'(WIDTH - 1);
                  busy_q <= 1'b1;
                  state_q <= CALC;
               end else begin
                  if (mthi) hi_q <= wdata;
                  if (mtlo) lo_q <= wdata;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= hi_fix;
               lo_q    <= lo_fix;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi, m_lo;   // bench model of architectural HI/LO

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive start for one edge; returns #1 after that edge (cycle 1)
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait for done; busy must stay high and HI/LO must hold until then
   task automatic wait_done(input string tag, input int c0, output int cyc);
      int bad_busy, bad_hold;
      bad_busy = 0; bad_hold = 0;
      cyc = c0;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy !== 1'b1) bad_busy++;
         if (hi !== m_hi || lo !== m_lo) bad_hold++;
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " busy-during-op"}, bad_busy, 0);
      check({tag, " hilo-hold"}, bad_hold, 0);
   endtask

   task automatic finish_check(input string tag, input int cyc, input logic [31:0] eh, input logic [31:0] el);
      check({tag, " latency"}, cyc, 34);
      check({tag, " done"}, {31'b0, done}, 1);
      check({tag, " busy"}, {31'b0, busy}, 0);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
      int cyc;
      launch(o, x, y);
      wait_done(tag, 1, cyc);
      finish_check(tag, cyc, eh, el);
   endtask

   initial begin
      int cyc, pulses;
      rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = OP_MULT; a = '0; b = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset busy", {31'b0, busy}, 0);
      check("reset done", {31'b0, done}, 0);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      m_hi = '0; m_lo = '0;

      // MTHI alone, then MTHI+MTLO together
      @(negedge clk); mthi = 1'b1; wdata = 32'hAAAA0000;
      @(posedge clk); #1 mthi = 1'b0;
      check("mthi hi", hi, 32'hAAAA0000);
      check("mthi lo", lo, 32'h0);
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A5A5A;
      @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b0;
      check("mthi+mtlo hi", hi, 32'h5A5A5A5A);
      check("mthi+mtlo lo", lo, 32'h5A5A5A5A);
      m_hi = 32'h5A5A5A5A; m_lo = 32'h5A5A5A5A;

      // Each run_op returns in the done cycle, so the next launch is back-to-back
      run_op("MULT -3*7",      OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("MULTU ffff^2",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("MULT -1*-1",     OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1);
      run_op("DIV -7/2",       OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("DIVU 7/2",       OP_DIVU,  32'd7,        32'd2,        32'h1,        32'h3);
      run_op("DIV /0",         OP_DIV,   32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF);
      run_op("DIVU /0",        OP_DIVU,  32'h9,        32'h0,        32'h9,        32'hFFFFFFFF);
      run_op("DIV min/-1",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
      run_op("DIV 100/-7",     OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h2,        32'hFFFFFFF2);

      // Start with MTLO in IDLE: start wins, MTLO dropped
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5; mtlo = 1'b1; wdata = 32'hDEADBEEF;
      @(posedge clk); #1 start = 1'b0; mtlo = 1'b0;
      check("start+mtlo lo kept", lo, m_lo);
      check("start+mtlo busy", {31'b0, busy}, 1);
      repeat (4) @(posedge clk);
      // Mid-CALC start and MTHI must both be ignored
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; mthi = 1'b1; wdata = 32'h55555555;
      @(posedge clk); #1 start = 1'b0; mthi = 1'b0;
      wait_done("MULTU 3*5", 6, cyc);
      finish_check("MULTU 3*5", cyc, 32'h0, 32'd15);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      check("no second op", pulses, 0);
      check("idle hi", hi, 32'h0);
      check("idle lo", lo, 32'd15);

      // Reset during iteration 10 of a DIVU aborts it
      launch(OP_DIVU, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("abort busy", {31'b0, busy}, 0);
      check("abort done", {31'b0, done}, 0);
      check("abort hi", hi, 32'h0);
      check("abort lo", lo, 32'h0);
      m_hi = '0; m_lo = '0;
      run_op("MULTU 6*7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
